// File: rtl/uart_tx_fifo_drain.sv
// Purpose : 8N1 UART transmitter that pops bytes from a FIFO read port and sends them LSB first.
// Latency : start bit begins 1 clk after fifo_empty_i=0 is seen in IDLE; each frame is 10*BAUD_DIV clks.
// Backpress: consumer only; pops one byte per frame (fifo_rd_o pulse), idles with tx high while empty.
module uart_tx_fifo_drain #(
    parameter int unsigned BAUD_DIV = 10417
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] fifo_rdata_i,
    input  logic       fifo_empty_i,
    output logic       fifo_rd_o,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    // tx_done is a flop, so it is armed one clk before the last stop-bit clk
    localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(BAUD_DIV - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             rd_q, rd_d;
    logic             done_q, done_d;
    logic             bit_end;
    logic [2:0]       bit_nxt;

    assign bit_end = (baud_q == BAUD_LAST);
    assign bit_nxt = bit_q + 3'd1;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: emptiness is only sampled in IDLE, so a pop is never based on a stale flag
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!fifo_empty_i)             state_d = START;
            START: if (bit_end)                   state_d = DATA;
            DATA:  if (bit_end && bit_q == 3'd7)  state_d = STOP;
            STOP:  if (bit_end)                   state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // Datapath next-state: baud/bit counters, latched byte and registered line/pop/done
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (!fifo_empty_i) begin
                // byte is captured here, so later head changes cannot corrupt the frame
                shreg_d = fifo_rdata_i;
                rd_d    = 1'b1;
                tx_d    = 1'b0;
            end
        end else begin
            baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
            case (state_q)
                START: begin
                    if (bit_end) begin
                        bit_d = 3'd0;
                        tx_d  = shreg_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
                            tx_d = 1'b1;
                        end else begin
                            bit_d = bit_nxt;
                            tx_d  = shreg_q[bit_nxt];
                        end
                    end
                end
                STOP: begin
                    tx_d = 1'b1;
                    if (baud_q == BAUD_PRE) begin
                        done_d = 1'b1;
                    end
                end
                default: tx_d = 1'b1;
            endcase
        end
    end

    // Datapath registers; reset forces the line high at once and drops any partial frame
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    // FSM outputs
    always_comb begin
        tx_busy_o = (state_q != IDLE);
        tx_o      = tx_q;
        fifo_rd_o = rd_q;
        tx_done_o = done_q;
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain at BAUD_DIV=16 with a queue-based FIFO and a frame-position model.
// Expected line level, pop, busy and done come from the frame position and the 8N1 bit layout.
// Inputs are driven at the falling edge; outputs are sampled at the falling edge.
module tb_uart_tx_fifo_drain;

    localparam int BD    = 16;
    localparam int FRAME = 10 * BD;

    logic       clk;
    logic       rst_n;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_rd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    uart_tx_fifo_drain #(.BAUD_DIV(BD)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .fifo_rdata_i (fifo_rdata),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_o    (fifo_rd),
        .tx_o         (tx),
        .tx_busy_o    (tx_busy),
        .tx_done_o    (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] q[$];
    int         m_pos   = -1;   // position within current frame, -1 when idle
    logic [7:0] m_byte  = 8'h00;
    logic [7:0] dec     = 8'h00;
    logic [7:0] idle_dat = 8'h3C;
    int         rd_cnt  = 0;
    int         done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (q.size() == 0);
        fifo_rdata = (q.size() != 0) ? q[0] : idle_dat;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        drive_fifo();
    endtask

    function automatic logic exp_line(input int pos, input logic [7:0] b);
        int k;
        if (pos < 0) return 1'b1;
        k = pos / BD;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // One clock: advance the model across the rising edge, then compare at the falling edge
    task automatic step();
        int k;
        @(negedge clk);
        if (!rst_n) begin
            m_pos = -1;
        end else if (m_pos >= 0) begin
            m_pos++;
            if (m_pos == FRAME) m_pos = -1;
        end else if (q.size() > 0) begin
            m_pos  = 0;
            m_byte = q.pop_front();
        end
        check("tx",      tx,      exp_line(m_pos, m_byte));
        check("busy",    tx_busy, m_pos >= 0);
        check("fifo_rd", fifo_rd, m_pos == 0);
        check("done",    tx_done, m_pos == FRAME - 1);
        if (m_pos >= BD && m_pos < 9 * BD && (m_pos % BD) == BD / 2) begin
            k = m_pos / BD - 1;
            dec[k] = tx;
        end
        if (m_pos == FRAME - 1) check("frame", dec, m_byte);
        if (fifo_rd) rd_cnt++;
        if (tx_done) done_cnt++;
        drive_fifo();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((q.size() != 0 || m_pos >= 0) && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", (q.size() == 0 && m_pos < 0), 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        q.delete();
        drive_fifo();

        // Reset held with a byte waiting: nothing may leave the block
        push(8'hA5);
        repeat (5) step();
        rst_n = 1'b1;

        // Single frame 0xA5, then a changed head byte while empty
        rd_cnt = 0; done_cnt = 0;
        step();
        check("first_pop", fifo_rd, 1'b1);
        idle_dat = 8'h3C;
        run_until_idle(FRAME + 20);
        repeat (30) step();
        check("a5_pops", rd_cnt, 1);
        check("a5_dones", done_cnt, 1);

        // Back-to-back frames
        rd_cnt = 0; done_cnt = 0;
        push(8'h00); push(8'hFF); push(8'h55);
        run_until_idle(4 * FRAME);
        repeat (5) step();
        check("b2b_pops", rd_cnt, 3);
        check("b2b_dones", done_cnt, 3);

        // Reset during data bit 3 of 0x81, with 0x42 queued behind it
        rd_cnt = 0; done_cnt = 0;
        push(8'h81);
        begin
            int n;
            n = 0;
            while (m_pos != 4 * BD + 5 && n < 2 * FRAME) begin
                step();
                n++;
            end
            check("reach_bit3", m_pos, 4 * BD + 5);
        end
        push(8'h42);
        rst_n = 1'b0;
        m_pos = -1;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        repeat (3) step();
        rst_n = 1'b1;
        run_until_idle(2 * FRAME);
        check("rst_pops", rd_cnt, 2);
        check("rst_dones", done_cnt, 1);

        // 16-deep fill
        rd_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        run_until_idle(17 * FRAME + 20);
        repeat (10) step();
        check("fill_pops", rd_cnt, 16);
        check("fill_dones", done_cnt, 16);
        check("fill_empty", fifo_empty, 1'b1);

        // Random bytes at random spacing, random head value while empty
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            idle_dat = 8'($urandom);
            push(8'($urandom));
            repeat ($urandom_range(0, 200)) step();
        end
        run_until_idle(9 * FRAME + 20);
        repeat (5) step();
        check("rand_pops", rd_cnt, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
